// File: rtl/rect_image_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rect_image_loader: byte-stream loader for a double-buffered 64x64x12 RAM |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module rect_image_loader #(
    parameter int          ADDR_W    = 12,
    parameter int          RGB_W     = 12,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              vblnk,
    input  logic [ADDR_W-1:0] pixel_addr,
    output logic [RGB_W-1:0]  rgb_pixel,
    output logic              load_busy,
    output logic              frame_done,
    output logic              fmt_err
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HI        = 2'd1,
        LO        = 2'd2,
        WAIT_SWAP = 2'd3
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  wcnt;
    logic [7:0]         rg;
    logic               front;
    logic               vblnk_d;

    logic [RGB_W-1:0]   bank_a [DEPTH];
    logic [RGB_W-1:0]   bank_b [DEPTH];

    logic               accept;
    logic               wr_en;
    logic [RGB_W-1:0]   wr_data;

    assign accept  = rx_valid && rx_ready;
    assign wr_en   = accept && (state == LO) && (rx_data[7:4] == 4'h0);
    assign wr_data = {rg, rx_data[3:0]};

    // Writes always target the back bank, so reads never collide with them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front) bank_a[wcnt] <= wr_data;
            else       bank_b[wcnt] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rgb_pixel <= '0;
        else      rgb_pixel <= front ? bank_b[pixel_addr] : bank_a[pixel_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            rg         <= '0;
            front      <= 1'b0;
            vblnk_d    <= 1'b0;
            rx_ready   <= 1'b0;
            load_busy  <= 1'b0;
            frame_done <= 1'b0;
            fmt_err    <= 1'b0;
        end else begin
            vblnk_d    <= vblnk;
            frame_done <= 1'b0;
            fmt_err    <= 1'b0;
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (accept && rx_data == SYNC_BYTE) begin
                        wcnt      <= '0;
                        state     <= HI;
                        load_busy <= 1'b1;
                    end
                end
                HI: begin
                    if (accept) begin
                        rg    <= rx_data;
                        state <= LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        if (rx_data[7:4] != 4'h0) begin
                            fmt_err   <= 1'b1;
                            state     <= IDLE;
                            load_busy <= 1'b0;
                        end else if (wcnt == LAST_ADDR) begin
                            state    <= WAIT_SWAP;
                            rx_ready <= 1'b0;
                        end else begin
                            wcnt  <= wcnt + 1'b1;
                            state <= HI;
                        end
                    end
                end
                WAIT_SWAP: begin
                    // vblnk_d is from before this state was entered only on
                    // the entry edge, so a level already high there is ignored.
                    if (vblnk && !vblnk_d) begin
                        front      <= ~front;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        rx_ready   <= 1'b1;
                        load_busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rect_image_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rect_image_loader: directed bench with a byte-level reference model   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_rect_image_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        vblnk = 1'b0;
    logic [11:0] pixel_addr = 12'h000;
    logic        rx_ready;
    logic [11:0] rgb_pixel;
    logic        load_busy;
    logic        frame_done;
    logic        fmt_err;

    rect_image_loader #(.ADDR_W(12), .RGB_W(12), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .vblnk      (vblnk),
        .pixel_addr (pixel_addr),
        .rgb_pixel  (rgb_pixel),
        .load_busy  (load_busy),
        .frame_done (frame_done),
        .fmt_err    (fmt_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: tracks the frame as a count of data bytes received.
    logic [11:0] ma [4096];
    logic [11:0] mb [4096];
    bit          va [4096];
    bit          vb [4096];
    int          mode = 0;          // 0 waiting for sync, 1 receiving, 2 awaiting swap
    int          nb = 0;
    logic [7:0]  hold = 8'h00;
    bit          mfront = 1'b0;
    bit          mvprev = 1'b0;
    bit          acc, rise;
    logic [11:0] px;
    logic        e_ready = 1'b0, e_busy = 1'b0, e_fd = 1'b0, e_fe = 1'b0;
    logic [11:0] e_rgb = 12'h000;
    bit          e_rgb_ok = 1'b1;

    initial begin
        for (int k = 0; k < 4096; k++) begin
            va[k] = 1'b0;
            vb[k] = 1'b0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode = 0; mfront = 1'b0; mvprev = 1'b0;
            e_ready = 1'b0; e_busy = 1'b0; e_fd = 1'b0; e_fe = 1'b0;
            e_rgb = 12'h000; e_rgb_ok = 1'b1;
        end else begin
            acc    = rx_valid && e_ready;
            rise   = vblnk && !mvprev;
            mvprev = vblnk;
            e_rgb    = mfront ? mb[pixel_addr] : ma[pixel_addr];
            e_rgb_ok = mfront ? vb[pixel_addr] : va[pixel_addr];
            e_fd = 1'b0;
            e_fe = 1'b0;
            if (mode == 0) begin
                if (acc && rx_data == 8'hA5) begin
                    mode = 1;
                    nb   = 0;
                end
            end else if (mode == 1) begin
                if (acc) begin
                    if (nb % 2 == 0) begin
                        hold = rx_data;
                        nb++;
                    end else if (rx_data[7:4] != 4'h0) begin
                        e_fe = 1'b1;
                        mode = 0;
                    end else begin
                        px = {hold, rx_data[3:0]};
                        if (mfront) begin ma[nb/2] = px; va[nb/2] = 1'b1; end
                        else        begin mb[nb/2] = px; vb[nb/2] = 1'b1; end
                        if (nb == 8191) mode = 2;
                        else            nb++;
                    end
                end
            end else if (rise) begin
                mfront = !mfront;
                e_fd   = 1'b1;
                mode   = 0;
            end
            e_ready = (mode != 2);
            e_busy  = (mode != 0);
        end
    end

    always @(negedge clk) begin
        check("rx_ready",   {31'd0, rx_ready},   {31'd0, e_ready});
        check("load_busy",  {31'd0, load_busy},  {31'd0, e_busy});
        check("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        check("fmt_err",    {31'd0, fmt_err},    {31'd0, e_fe});
        if (e_rgb_ok) check("rgb_pixel", {20'd0, rgb_pixel}, {20'd0, e_rgb});
    end

    function automatic logic [11:0] pat(int k, logic [11:0] mask);
        logic [11:0] a;
        a = k[11:0];
        return {a[3:0], a[7:4], a[11:8]} ^ mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        int guard;
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        do begin
            ok = rx_ready;
            tick();
            guard++;
        end while (!ok && guard < 50);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %0h not accepted, rx_ready stayed %0b", b, rx_ready);
        end
    endtask

    task automatic send_pixels(int first, int last, logic [11:0] mask);
        logic [11:0] p;
        for (int k = first; k <= last; k++) begin
            p = pat(k, mask);
            send(p[11:4]);
            send({4'h0, p[3:0]});
        end
    endtask

    task automatic count_done(int n, output int c);
        c = 0;
        repeat (n) begin
            tick();
            if (frame_done === 1'b1) c++;
        end
    endtask

    task automatic pulse_vblnk(output int c);
        vblnk = 1'b1;
        count_done(3, c);
        vblnk = 1'b0;
        tick();
    endtask

    task automatic sweep();
        for (int a = 0; a < 4096; a++) begin
            pixel_addr = a[11:0];
            tick();
        end
        tick();
    endtask

    int          nd;
    logic [11:0] p2000;

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        check("reset_rx_ready",  {31'd0, rx_ready},  32'd0);
        check("reset_load_busy", {31'd0, load_busy}, 32'd0);
        check("reset_rgb",       {20'd0, rgb_pixel}, 32'd0);
        rst = 1'b1;
        check("ready_before_edge", {31'd0, rx_ready}, 32'd0);
        tick();
        check("ready_after_release", {31'd0, rx_ready}, 32'd1);

        send(8'h12);
        rx_valid = 1'b0;
        tick();
        check("busy_after_junk", {31'd0, load_busy}, 32'd0);
        send(8'hA5);
        check("busy_after_sync", {31'd0, load_busy}, 32'd1);

        // Frame 1 into bank B
        pixel_addr = 12'h123;
        send_pixels(0, 4095, 12'h000);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (10) tick();
        check("wait_rx_ready", {31'd0, rx_ready},  32'd0);
        check("wait_busy",     {31'd0, load_busy}, 32'd1);
        rx_valid = 1'b0;
        pulse_vblnk(nd);
        check("frame1_done_count", nd, 32'd1);
        sweep();
        pixel_addr = 12'h123;
        tick();
        check("frame1_rgb_123", {20'd0, rgb_pixel}, 32'h321);

        // Frame 2 into bank A, vblnk already high on entry to the swap wait
        send(8'hA5);
        send_pixels(0, 4094, 12'hFFF);
        vblnk = 1'b1;
        send_pixels(4095, 4095, 12'hFFF);
        rx_valid = 1'b0;
        check("old_front_at_last", {20'd0, rgb_pixel}, 32'h321);
        count_done(6, nd);
        check("no_swap_on_high_vblnk", nd, 32'd0);
        check("old_front_in_wait", {20'd0, rgb_pixel}, 32'h321);
        vblnk = 1'b0;
        tick();
        pulse_vblnk(nd);
        check("frame2_done_count", nd, 32'd1);
        sweep();
        pixel_addr = 12'h123;
        tick();
        check("frame2_rgb_123", {20'd0, rgb_pixel}, 32'hCDE);

        // Frame 3 into bank B
        send(8'hA5);
        send_pixels(0, 4095, 12'h5A5);
        rx_valid = 1'b0;
        pulse_vblnk(nd);
        check("frame3_done_count", nd, 32'd1);
        tick();
        check("frame3_rgb_123", {20'd0, rgb_pixel}, 32'h684);

        // Malformed pixel aimed at bank A address 0
        send(8'hA5);
        send(8'h3C);
        send(8'h15);
        rx_valid = 1'b0;
        check("fmt_err_pulse", {31'd0, fmt_err}, 32'd1);
        tick();
        check("fmt_err_clear", {31'd0, fmt_err},   32'd0);
        check("fmt_idle",      {31'd0, load_busy}, 32'd0);

        // Reset exposes bank A: address 0 must still hold frame 2 data
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        pixel_addr = 12'h000;
        repeat (3) tick();
        check("bankA_addr0_kept", {20'd0, rgb_pixel}, 32'hFFF);

        // Frame 4 aborted by reset during pixel 2000
        send(8'hA5);
        send_pixels(0, 1999, 12'h000);
        p2000 = pat(2000, 12'h000);
        send(p2000[11:4]);
        rst = 1'b0;
        #1;
        check("async_rst_busy",  {31'd0, load_busy}, 32'd0);
        check("async_rst_ready", {31'd0, rx_ready},  32'd0);
        check("async_rst_rgb",   {20'd0, rgb_pixel}, 32'd0);
        rx_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Frame 5 into bank B after reset
        send(8'hA5);
        send_pixels(0, 4095, 12'h000);
        rx_valid = 1'b0;
        pulse_vblnk(nd);
        check("frame5_done_count", nd, 32'd1);
        sweep();
        pixel_addr = 12'h7D0;
        tick();
        check("frame5_rgb_7d0", {20'd0, rgb_pixel}, 32'h0D7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
